mul_arbiter: RTL and testbench

//  Shares one 256-bit modular multiplier (mod P, Done-handshake multiplier) between N_REQ point-arithmetic

---
 rtl/mul_arbiter.sv | 147 ++++++++++++++
 tb/tb_mul_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one Done-handshake modular multiplier between N_REQ requesters.
// Latches operands, sequences the multiplier reset between jobs and aborts hung jobs via a watchdog.
module mul_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 256,
    parameter int TIMEOUT = 1024
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic               rsp_err,
    output logic [W-1:0]       rsp_product,
    output logic               busy,
    output logic               mul_rst,
    output logic [W-1:0]       mul_a,
    output logic [W-1:0]       mul_b,
    input  logic               mul_done,
    input  logic [W-1:0]       mul_product,
    output logic [1:0]         dbg_state_o
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT) + 1;

    // Handshake: req is level, held until its gnt pulse; gnt and rsp_valid are single-cycle
    // one-hot pulses; operands are sampled on the edge that raises gnt.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_BUSY   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t             state_q;
    logic [IW-1:0]      rr_ptr_q;
    logic [IW-1:0]      idx_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [N_REQ-1:0]   rsp_valid_q;
    logic               rsp_err_q;
    logic [W-1:0]       rsp_product_q;
    logic               busy_q;
    logic               mul_rst_q;
    logic [W-1:0]       mul_a_q;
    logic [W-1:0]       mul_b_q;
    logic [CW-1:0]      wd_cnt_q;
    logic               first_q;

    logic               pick_valid_d;
    logic [IW-1:0]      pick_idx_d;
    logic [IW-1:0]      rr_ptr_d;

    // Walk downward so the closest set bit at or after rr_ptr is the last one written.
    always_comb begin
        int j;
        j            = 0;
        pick_valid_d = 1'b0;
        pick_idx_d   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(rr_ptr_q) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (req[j]) begin
                pick_valid_d = 1'b1;
                pick_idx_d   = j[IW-1:0];
            end
        end
        rr_ptr_d = (pick_idx_d == IW'(N_REQ - 1)) ? '0 : pick_idx_d + 1'b1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            idx_q         <= '0;
            gnt_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_product_q <= '0;
            busy_q        <= 1'b0;
            mul_rst_q     <= 1'b1;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            wd_cnt_q      <= '0;
            first_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    mul_rst_q <= 1'b1;
                    if (pick_valid_d) begin
                        gnt_q    <= N_REQ'(1) << pick_idx_d;
                        mul_a_q  <= req_a[pick_idx_d*W +: W];
                        mul_b_q  <= req_b[pick_idx_d*W +: W];
                        idx_q    <= pick_idx_d;
                        rr_ptr_q <= rr_ptr_d;
                        busy_q   <= 1'b1;
                        state_q  <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    gnt_q     <= '0;
                    mul_rst_q <= 1'b0;
                    wd_cnt_q  <= '0;
                    first_q   <= 1'b1;
                    state_q   <= S_BUSY;
                end
                S_BUSY: begin
                    // Done seen in the first BUSY cycle may be left over from the previous job.
                    first_q  <= 1'b0;
                    wd_cnt_q <= wd_cnt_q + 1'b1;
                    if (!first_q && mul_done) begin
                        rsp_product_q <= mul_product;
                        rsp_valid_q   <= N_REQ'(1) << idx_q;
                        rsp_err_q     <= 1'b0;
                        state_q       <= S_RESP;
                    end else if (wd_cnt_q == CW'(TIMEOUT - 1)) begin
                        rsp_product_q <= '0;
                        rsp_valid_q   <= N_REQ'(1) << idx_q;
                        rsp_err_q     <= 1'b1;
                        state_q       <= S_RESP;
                    end
                end
                S_RESP: begin
                    rsp_valid_q <= '0;
                    rsp_err_q   <= 1'b0;
                    mul_rst_q   <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_product = rsp_product_q;
    assign busy        = busy_q;
    assign mul_rst     = mul_rst_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: stub multiplier with random latency, arbitration/product scoreboard,
// watchdog, mid-job reset and stale-done scenarios.
module tb_mul_arbiter;

    localparam int N  = 4;
    localparam int W  = 256;
    localparam int TO = 1024;
    localparam logic [W-1:0] P = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;

    logic           Clk, Reset_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   gnt, rsp_valid;
    logic           rsp_err, busy, mul_rst, mul_done;
    logic [W-1:0]   rsp_product, mul_a, mul_b, mul_product;
    logic [1:0]     dbg_state;

    mul_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_product(rsp_product),
        .busy(busy), .mul_rst(mul_rst), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_product(mul_product), .dbg_state_o(dbg_state)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] x;
        x = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        x = x % {{W{1'b0}}, P};
        return x[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        v[W-1] = 1'b0;
        return v;
    endfunction

    // Stub multiplier: leaves Init on the first edge after reset drops, done after a random delay.
    // Done and product are kept while held in reset, mimicking a stale Finish state.
    logic         hang = 1'b0;
    logic         stub_run = 1'b0;
    int           stub_cnt = 0;
    logic         stub_done = 1'b0;
    logic [W-1:0] stub_prod = '0;
    assign mul_done    = stub_done;
    assign mul_product = stub_prod;

    always @(posedge Clk) begin
        if (mul_rst) begin
            stub_run <= 1'b0;
        end else if (!stub_run) begin
            stub_run  <= 1'b1;
            stub_done <= 1'b0;
            stub_cnt  <= $urandom_range(20, 2);
        end else if (!hang && stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
                stub_done <= 1'b1;
                stub_prod <= mulmod(mul_a, mul_b);
            end
        end
    end

    // Requests as the DUT saw them at the last rising edge.
    logic [N-1:0]   snap_req;
    logic [N*W-1:0] snap_a, snap_b;
    always @(posedge Clk) begin
        snap_req = req;
        snap_a   = req_a;
        snap_b   = req_b;
    end

    // Scoreboard: reference round-robin pointer and expected responses in grant order.
    int           ptr = 0;
    logic [W-1:0] exp_q[$];
    int           idx_q[$];
    logic         err_q[$];

    always @(negedge Clk) begin
        if (Reset_n) begin
            if (gnt != '0) begin
                int e;
                e = -1;
                for (int k = 0; k < N; k++)
                    if (e < 0 && snap_req[(ptr + k) % N]) e = (ptr + k) % N;
                if (e < 0) begin
                    check_eq("gnt_unexpected", W'(gnt), '0);
                end else begin
                    check_eq("gnt_rr", W'(gnt), W'(1) << e);
                    exp_q.push_back(hang ? '0 : mulmod(snap_a[e*W +: W], snap_b[e*W +: W]));
                    idx_q.push_back(e);
                    err_q.push_back(hang);
                    ptr = (e + 1) % N;
                end
            end
            if (rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    check_eq("rsp_unexpected", W'(rsp_valid), '0);
                end else begin
                    logic [W-1:0] ep;
                    int           ei;
                    logic         ee;
                    ep = exp_q.pop_front();
                    ei = idx_q.pop_front();
                    ee = err_q.pop_front();
                    check_eq("rsp_idx", W'(rsp_valid), W'(1) << ei);
                    check_eq("rsp_product", rsp_product, ep);
                    check_eq("rsp_err", W'(rsp_err), W'(ee));
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req[i]          = 1'b1;
    endtask

    task automatic run_single(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] exp_p, input logic exp_e);
        int cyc;
        @(negedge Clk);
        set_req(i, a, b);
        for (int n = 0; n < 20; n++) begin
            @(negedge Clk);
            if (gnt != '0) break;
        end
        check_eq("single_gnt", W'(gnt), W'(1) << i);
        req[i] = 1'b0;
        cyc = 0;
        for (int n = 0; n < TO + 50; n++) begin
            @(negedge Clk);
            cyc++;
            if (rsp_valid != '0) break;
        end
        check_eq("single_rsp_valid", W'(rsp_valid), W'(1) << i);
        check_eq("single_product", rsp_product, exp_p);
        check_eq("single_err", W'(rsp_err), W'(exp_e));
        if (exp_e) check_eq("timeout_latency", W'(cyc), W'(TO + 1));
        @(negedge Clk);
        check_eq("after_rsp_valid", W'(rsp_valid), '0);
        check_eq("after_busy", W'(busy), '0);
        check_eq("after_mul_rst", W'(mul_rst), W'(1));
    endtask

    // Every requester re-raises the cycle after its own grant, so grants must cycle 0,1,2,3,...
    task automatic run_rr(input int n_jobs);
        int k;
        k = 0;
        for (int i = 0; i < N; i++) set_req(i, rand_op(), rand_op());
        for (int c = 0; c < n_jobs * 40 + 100 && k < n_jobs; c++) begin
            @(negedge Clk);
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) begin
                    check_eq("rr_order", W'(gnt), W'(1) << (k % N));
                    k++;
                    req[i] = 1'b0;
                end else if (!req[i] && k < n_jobs) begin
                    set_req(i, rand_op(), rand_op());
                end
            end
        end
        check_eq("rr_jobs_done", W'(k), W'(n_jobs));
        req = '0;
    endtask

    task automatic drain();
        for (int c = 0; c < 2000; c++) begin
            @(negedge Clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        check_eq("drain", W'(exp_q.size()), '0);
    endtask

    initial begin
        logic [W-1:0] a, b;
        Reset_n = 1'b0;
        req     = '0;
        req_a   = '0;
        req_b   = '0;
        repeat (3) @(negedge Clk);
        check_eq("rst_gnt", W'(gnt), '0);
        check_eq("rst_rsp_valid", W'(rsp_valid), '0);
        check_eq("rst_rsp_err", W'(rsp_err), '0);
        check_eq("rst_product", rsp_product, '0);
        check_eq("rst_busy", W'(busy), '0);
        check_eq("rst_mul_rst", W'(mul_rst), W'(1));
        check_eq("rst_mul_a", mul_a, '0);
        check_eq("rst_mul_b", mul_b, '0);
        check_eq("rst_state", W'(dbg_state), '0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        run_rr(12);
        drain();

        run_single(0, W'(3), W'(5), W'(15), 1'b0);
        run_single(2, P - 1, P - 1, W'(1), 1'b0);
        a = '0;
        a[W-1] = 1'b1;
        run_single(2, a, W'(2), W'(64'h1000003D1), 1'b0);

        for (int t = 0; t < 16; t++) begin
            int i;
            i = $urandom_range(N - 1, 0);
            a = rand_op();
            b = rand_op();
            run_single(i, a, b, mulmod(a, b), 1'b0);
        end

        hang = 1'b1;
        run_single(2, rand_op(), rand_op(), '0, 1'b1);
        hang = 1'b0;

        // Reset while the multiplier is hung in BUSY: job dropped, no response.
        hang = 1'b1;
        @(negedge Clk);
        set_req(1, rand_op(), rand_op());
        for (int n = 0; n < 20; n++) begin
            @(negedge Clk);
            if (gnt != '0) break;
        end
        req[1] = 1'b0;
        repeat (6) @(negedge Clk);
        check_eq("midrun_busy_before", W'(busy), W'(1));
        Reset_n = 1'b0;
        #1;
        check_eq("midrun_mul_rst", W'(mul_rst), W'(1));
        check_eq("midrun_busy", W'(busy), '0);
        check_eq("midrun_rsp_valid", W'(rsp_valid), '0);
        exp_q.delete();
        idx_q.delete();
        err_q.delete();
        ptr = 0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        hang = 1'b0;
        repeat (3) @(negedge Clk);
        run_single(1, W'(7), W'(9), W'(63), 1'b0);

        // Done is still high with product 63 from the previous job.
        check_eq("stale_done_high", W'(mul_done), W'(1));
        run_single(3, W'(4), W'(4), W'(16), 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
